// File: rtl/word_byte_tx_pkg.sv
// Shared constants for the word-to-byte transmitter: bus widths, FSM state
// encodings and the byte parity helper.
package word_byte_tx_pkg;

  localparam int WBT_BYTE_W = 8;
  localparam int WBT_WORD_W = 2 * WBT_BYTE_W;

  // FSM encodings; 2'd3 is illegal and recovers to ST_IDLE
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND_HI = 2'd1;
  localparam logic [1:0] ST_SEND_LO = 2'd2;

  // Even parity of one bus byte
  function automatic logic even_par(input logic [WBT_BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/word_byte_tx_word_fifo.sv
// word_fifo: small synchronous FIFO with an occupancy counter.
// Pushes into a full FIFO and pops from an empty one are ignored.
// flush empties the FIFO on the next edge and wins over push/pop.
module word_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == LW'(DEPTH));
  assign empty     = (count_q == {LW{1'b0}});
  assign level     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; pointers wrap mod DEPTH
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {LW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/word_byte_tx.sv
// word_byte_tx: buffers 16-bit words and sends each as two byte beats,
// high byte first, qualified by byte_ena and back-pressured by byte_ready.
// Optional feature macro: WBT_PARITY_EN adds the registered byte_par output.
module word_byte_tx
  import word_byte_tx_pkg::*;
#(
  parameter  int WORD_W     = WBT_WORD_W,
  parameter  int BYTE_W     = WBT_BYTE_W,
  parameter  int FIFO_DEPTH = 2,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              flush,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_ena,
  input  logic              byte_ready,
  output logic [LVL_W-1:0]  level,
  output logic              busy
`ifdef WBT_PARITY_EN
  ,
  output logic              byte_par
`endif
);

  logic [1:0]        state_q, state_d;
  logic [BYTE_W-1:0] sh_lo_q, sh_lo_d;   // pending low byte of the word in flight
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              ena_q, ena_d;
  logic [WORD_W-1:0] head_s;
  logic              full_s, empty_s, push_s, pop_s;
  logic [LVL_W-1:0]  level_s;

  // A word offered during flush is dropped along with the FIFO contents
  assign push_s = word_valid & ~full_s & ~flush;

  word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk   (clk1),
    .rst   (rst),
    .flush (flush),
    .push  (push_s),
    .wdata (word_in),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  assign word_ready = ~full_s;
  assign level      = level_s;
  assign busy       = (state_q != ST_IDLE) || (level_s != {LVL_W{1'b0}});
  assign byte_out   = byte_q;
  assign byte_ena   = ena_q;

  // Beat sequencing: pop into the shift stage, send high then low, chain
  // the next word without a bubble, idle with ena low and byte zero
  always_comb begin
    state_d = state_q;
    sh_lo_d = sh_lo_q;
    byte_d  = byte_q;
    ena_d   = ena_q;
    pop_s   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      byte_d  = {BYTE_W{1'b0}};
      ena_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            sh_lo_d = head_s[BYTE_W-1:0];
            byte_d  = head_s[WORD_W-1 -: BYTE_W];
            ena_d   = 1'b1;
            state_d = ST_SEND_HI;
          end else begin
            byte_d  = {BYTE_W{1'b0}};
            ena_d   = 1'b0;
          end
        end
        ST_SEND_HI: begin
          if (byte_ready) begin
            byte_d  = sh_lo_q;
            state_d = ST_SEND_LO;
          end else begin
            state_d = ST_SEND_HI;
          end
        end
        ST_SEND_LO: begin
          if (byte_ready && !empty_s) begin
            pop_s   = 1'b1;
            sh_lo_d = head_s[BYTE_W-1:0];
            byte_d  = head_s[WORD_W-1 -: BYTE_W];
            ena_d   = 1'b1;
            state_d = ST_SEND_HI;
          end else if (byte_ready) begin
            byte_d  = {BYTE_W{1'b0}};
            ena_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND_LO;
          end
        end
        default: begin
          byte_d  = {BYTE_W{1'b0}};
          ena_d   = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM, shift stage and output registers
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_lo_q <= {BYTE_W{1'b0}};
      byte_q  <= {BYTE_W{1'b0}};
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_lo_q <= sh_lo_d;
      byte_q  <= byte_d;
      ena_q   <= ena_d;
    end
  end

`ifdef WBT_PARITY_EN
  logic par_q, par_d;

  // Parity tracks the next byte and is forced low while ena is low
  always_comb begin
    par_d = even_par(byte_d) & ena_d;
  end

  // Parity register, aligned with byte_out
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign byte_par = par_q;
`endif

endmodule

// File: tb/tb_word_byte_tx.sv
// Self-checking bench for word_byte_tx: directed scenarios plus a random
// run, checked against a queue-based model of words and byte beats.
module tb_word_byte_tx;

  localparam int DEPTH = 2;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [15:0] word_in;
  logic        word_valid, word_ready, flush, byte_ena, byte_ready, busy;
  logic [7:0]  byte_out;
  logic [1:0]  level;
`ifdef WBT_PARITY_EN
  logic        byte_par;
`endif

  word_byte_tx #(.WORD_W(16), .BYTE_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk1(clk1), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .flush(flush), .byte_out(byte_out),
    .byte_ena(byte_ena), .byte_ready(byte_ready), .level(level), .busy(busy)
`ifdef WBT_PARITY_EN
    , .byte_par(byte_par)
`endif
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queued words, the word in flight and which of its bytes is on the bus
  bit [15:0] wq[$];
  bit [15:0] cur;
  int        phase;        // 0 nothing on bus, 1 high byte shown, 2 low byte shown
  bit [7:0]  exp_byte;
  bit        exp_ena;
  bit [12:0] exp_vec;      // {byte, ena, level, busy, ready}
  bit [7:0]  rx[$];        // bytes the receiver actually took
  bit [7:0]  exp_rx[$];    // bytes it should take, from accepted words

  task automatic model_reset();
    wq.delete(); phase = 0; exp_byte = 8'h00; exp_ena = 1'b0; cur = 16'h0;
    exp_vec = {8'h00, 1'b0, 2'd0, 1'b0, 1'b1};
  endtask

  // Drive one cycle, record receiver beats, advance the model at the edge
  task automatic step(input bit vld, input bit [15:0] w, input bit rdy, input bit fl);
    bit can_push;
    word_valid = vld; word_in = w; byte_ready = rdy; flush = fl;
    #1;
    if (byte_ena && byte_ready) rx.push_back(byte_out);
    can_push = vld && !fl && (wq.size() < DEPTH);
    if (can_push) begin exp_rx.push_back(w[15:8]); exp_rx.push_back(w[7:0]); end
    @(posedge clk1);
    if (fl) begin
      wq.delete(); phase = 0; exp_byte = 8'h00; exp_ena = 1'b0;
    end else begin
      if (phase == 0 || (phase == 2 && rdy)) begin
        if (wq.size() > 0) begin
          cur = wq.pop_front(); phase = 1; exp_byte = cur[15:8]; exp_ena = 1'b1;
        end else begin
          phase = 0; exp_byte = 8'h00; exp_ena = 1'b0;
        end
      end else if (phase == 1 && rdy) begin
        phase = 2; exp_byte = cur[7:0];
      end
      if (can_push) wq.push_back(w);
    end
    exp_vec = {exp_byte, exp_ena, 2'(wq.size()), (phase != 0) || (wq.size() != 0),
               wq.size() < DEPTH};
    @(negedge clk1);
  endtask

  task automatic do_reset();
    rst = 1'b1; word_valid = 1'b0; word_in = 16'h0; byte_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    model_reset(); rx.delete(); exp_rx.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({byte_out, byte_ena, level, busy, word_ready} !== 13'h0001) begin
      n_fail++;
      $display("FAIL reset_state: got byte=%h ena=%b lvl=%0d busy=%b rdy=%b, want 00/0/0/0/1",
               byte_out, byte_ena, level, busy, word_ready);
    end
  endtask

  task automatic test_single();
    int ena_cnt = 0;
    step(1'b1, 16'hA55A, 1'b1, 1'b0);
    n_checks++;
    if (byte_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: ena=%b one cycle after push, want 0", byte_ena);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      if (byte_ena) ena_cnt++;
      n_checks++;
      if ({byte_out, byte_ena, level, busy, word_ready} !== exp_vec) begin
        n_fail++;
        $display("FAIL single_cycle%0d: got %h want %h", i,
                 {byte_out, byte_ena, level, busy, word_ready}, exp_vec);
      end
    end
    n_checks++;
    if (ena_cnt != 2 || rx.size() != 2 || rx[0] !== 8'hA5 || rx[1] !== 8'h5A || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_bytes: ena_cycles=%0d n=%0d busy=%b, want 2 cycles A5,5A idle",
               ena_cnt, rx.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    bit [15:0] words [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    bit [7:0]  want  [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    int  k = 0, cyc = 0;
    bit  saw_full = 1'b0, gap = 1'b0, started = 1'b0;
    rx.delete(); exp_rx.delete();
    while ((k < 3 || busy) && cyc < 30) begin
      if (k < 3 && word_ready) begin step(1'b1, words[k], 1'b1, 1'b0); k++; end
      else step(1'b0, 16'h0, 1'b1, 1'b0);
      cyc++;
      if (byte_ena) started = 1'b1;
      else if (started && (k < 3 || level != 2'd0 || rx.size() < 5)) gap = 1'b1;
      if (level == 2'd2 && word_ready === 1'b0) saw_full = 1'b1;
      n_checks++;
      if ({byte_out, byte_ena, level, busy, word_ready} !== exp_vec) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got %h want %h", cyc,
                 {byte_out, byte_ena, level, busy, word_ready}, exp_vec);
      end
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if (cyc >= 30 || k != 3) begin
      n_fail++;
      $display("FAIL b2b_timeout: pushed %0d of 3 in %0d cycles", k, cyc);
    end
    n_checks++;
    if (!saw_full || gap) begin
      n_fail++;
      $display("FAIL b2b_flow: saw_full=%b gap=%b, want 1 0", saw_full, gap);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rx.size() <= i || rx[i] !== want[i]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h want %h", i, (rx.size() > i) ? rx[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0);
      n_checks++;
      if (byte_out !== 8'hBE || byte_ena !== 1'b1 || {byte_out, byte_ena, level, busy, word_ready} !== exp_vec) begin
        n_fail++;
        $display("FAIL stall_hold%0d: byte=%h ena=%b, want BE 1", i, byte_out, byte_ena);
      end
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if (byte_out !== 8'hEF || byte_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_lo: byte=%h ena=%b, want EF 1", byte_out, byte_ena);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if (byte_ena !== 1'b0 || busy !== 1'b0 || byte_out !== 8'h00) begin
      n_fail++;
      $display("FAIL stall_idle: byte=%h ena=%b busy=%b, want 00 0 0", byte_out, byte_ena, busy);
    end
  endtask

  task automatic test_random_push_pop();
    rx.delete(); exp_rx.delete();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      n_checks++;
      if ({byte_out, byte_ena, level, busy, word_ready} !== exp_vec) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h want %h", i,
                 {byte_out, byte_ena, level, busy, word_ready}, exp_vec);
      end
`ifdef WBT_PARITY_EN
      n_checks++;
      if (byte_par !== (^exp_byte & exp_ena)) begin
        n_fail++;
        $display("FAIL random_par%0d: got %b want %b", i, byte_par, ^exp_byte & exp_ena);
      end
`endif
    end
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if (rx != exp_rx) begin
      n_fail++;
      $display("FAIL random_stream: got %0d bytes want %0d, contents differ",
               rx.size(), exp_rx.size());
    end
  endtask

  task automatic test_flush();
    step(1'b1, 16'h1111, 1'b1, 1'b0);
    step(1'b1, 16'h2222, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if (level !== 2'd1 || byte_out !== 8'h11) begin
      n_fail++;
      $display("FAIL flush_setup: lvl=%0d byte=%h, want 1 11", level, byte_out);
    end
    step(1'b1, 16'h3333, 1'b1, 1'b1);
    n_checks++;
    if (byte_ena !== 1'b0 || level !== 2'd0 || busy !== 1'b0 || byte_out !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_clear: ena=%b lvl=%0d busy=%b byte=%h, want 0 0 0 00", byte_ena, level, busy, byte_out);
    end
    rx.delete();
    for (int i = 0; i < 5; i++) step((i == 0), 16'h00FF, 1'b1, 1'b0);
    n_checks++;
    if (rx.size() != 2 || rx[0] !== 8'h00 || rx[1] !== 8'hFF) begin
      n_fail++;
      $display("FAIL flush_resume: got %0d bytes, want 00,FF", rx.size());
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h0707, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    n_checks++;
    if (byte_out !== 8'h07 || byte_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_setup: byte=%h ena=%b, want 07 1", byte_out, byte_ena);
    end
`ifdef WBT_PARITY_EN
    n_checks++;
    if (byte_par !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_par: got %b want 1", byte_par);
    end
`endif
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({byte_out, byte_ena, level, busy, word_ready} !== 13'h0001) begin
      n_fail++;
      $display("FAIL arst_immediate: byte=%h ena=%b lvl=%0d busy=%b rdy=%b", byte_out, byte_ena, level, busy, word_ready);
    end
`ifdef WBT_PARITY_EN
    n_checks++;
    if (byte_par !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_par_clear: got %b want 0", byte_par);
    end
`endif
    @(negedge clk1);
    rst = 1'b0;
    model_reset();
    step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if ({byte_out, byte_ena, level, busy, word_ready} !== exp_vec) begin
      n_fail++;
      $display("FAIL arst_after: got %h want %h", {byte_out, byte_ena, level, busy, word_ready}, exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_random_push_pop();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
